// File: rtl/piradip_cdc_send_arbiter.sv
// Round-robin arbiter that feeds a four-phase handshake CDC (xpm_cdc_handshake style) from
// NREQ source-domain requesters. One word is in flight at a time. The granted requester's
// tag and payload are registered into cdc_src_in and stay there until the next grant.
//
// Ports:
//   clk          source-domain clock
//   resetn       synchronous active-low reset
//   req_valid    per-requester word pending
//   req_data     requester i payload at [i*WIDTH +: WIDTH]
//   req_ready    one-cycle accept pulse to the granted requester (combinational in IDLE)
//   cdc_src_in   {tag, payload} to the handshake CDC
//   cdc_src_send handshake request to the CDC
//   cdc_src_rcv  handshake acknowledge from the CDC
//   busy         high whenever the FSM is not IDLE
//   grant_id     index of the last granted requester
//   timeout_err  sticky flag, set when a SEND phase lasts TIMEOUT cycles
//   err_clr      clears timeout_err (a same-cycle set wins)
module piradip_cdc_send_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1024,
    localparam int unsigned TAG_W  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH+TAG_W-1:0]  cdc_src_in,
    output logic                    cdc_src_send,
    input  logic                    cdc_src_rcv,
    output logic                    busy,
    output logic [TAG_W-1:0]        grant_id,
    output logic                    timeout_err,
    input  logic                    err_clr
);

    typedef enum logic [1:0] {StIdle, StSend, StWaitLow} state_e;

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e                  state_q, state_d;
    logic [TAG_W-1:0]        grant_id_q, grant_id_d;
    logic [WIDTH+TAG_W-1:0]  src_in_q, src_in_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic                    hit;
    logic [TAG_W-1:0]        pick;
    logic                    do_grant;

    // Round-robin search starting one past the last grant, wrapping at NREQ.
    always_comb begin
        int unsigned idx;
        idx  = 0;
        hit  = 1'b0;
        pick = grant_id_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(grant_id_q) + k) % NREQ;
            if (!hit && req_valid[idx]) begin
                hit  = 1'b1;
                pick = TAG_W'(idx);
            end
        end
    end

    // A high rcv in IDLE means the CDC has not finished its return-to-zero yet.
    assign do_grant = resetn && (state_q == StIdle) && hit && !cdc_src_rcv;

    always_comb begin
        req_ready = '0;
        if (do_grant) begin
            req_ready = NREQ'(1) << pick;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        src_in_d   = src_in_q;
        cnt_d      = cnt_q;
        err_d      = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (do_grant) begin
                    state_d    = StSend;
                    grant_id_d = pick;
                    src_in_d   = {pick, req_data[pick*WIDTH +: WIDTH]};
                    cnt_d      = '0;
                end
            end
            StSend: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Fires once, on the SEND cycle that brings the count to TIMEOUT; overrides err_clr.
                if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    err_d = 1'b1;
                end
                if (cdc_src_rcv) begin
                    state_d = StWaitLow;
                end
            end
            StWaitLow: begin
                if (!cdc_src_rcv) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            grant_id_q <= TAG_W'(NREQ - 1);
            src_in_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            src_in_q   <= src_in_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign cdc_src_in   = src_in_q;
    assign cdc_src_send = (state_q == StSend);
    assign busy         = (state_q != StIdle);
    assign grant_id     = grant_id_q;
    assign timeout_err  = err_q;

endmodule

// File: doc/piradip_cdc_send_arbiter.md
PIRADIP_CDC_SEND_ARBITER -- requirements
Module: piradip_cdc_send_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of source-domain requesters (2..16).
REQ-002 SHALL have parameter WIDTH, default 32, payload bits per requester.
REQ-003 SHALL have parameter TIMEOUT, default 1024, SEND-state cycles before timeout_err (0 disables the timeout).
REQ-004 SHALL derive localparam TAG_W = max(1, clog2(NREQ)).
REQ-005 SHALL have port clk, input, 1, single clock (the CDC source-domain clock).
REQ-006 SHALL have port resetn, input, 1; reset is synchronous and active-low.
REQ-007 SHALL have port req_valid, input, NREQ, per-requester word pending.
REQ-008 SHALL have port req_data, input, NREQ*WIDTH, requester i payload at [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_ready, output, NREQ, one-cycle accept pulse to the granted requester.
REQ-010 SHALL have port cdc_src_in, output, WIDTH+TAG_W, {tag, payload} to the handshake CDC src_in.
REQ-011 SHALL have port cdc_src_send, output, 1, to the handshake CDC src_send.
REQ-012 SHALL have port cdc_src_rcv, input, 1, from the handshake CDC src_rcv.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-014 SHALL have port grant_id, output, TAG_W, index of the last granted requester.
REQ-015 SHALL have port timeout_err, output, 1, sticky timeout flag.
REQ-016 SHALL have port err_clr, input, 1, clears timeout_err.

Function
REQ-017 SHALL implement FSM states IDLE, SEND and WAIT_LOW.
REQ-018 IDLE: if any req_valid is high and cdc_src_rcv is low, grant one requester round-robin, searching from (grant_id+1) mod NREQ upward with wrap.
REQ-019 On grant: pulse req_ready[g] for exactly that cycle; register {g, req_data[g]} into cdc_src_in; set grant_id=g; next state SEND.
REQ-020 A requester SHALL treat the req_valid && req_ready cycle as the transfer; the block SHALL NOT sample req_data at any other time.
REQ-021 SEND: cdc_src_send=1 and cdc_src_in held constant; when cdc_src_rcv=1, deassert cdc_src_send on the next edge and go to WAIT_LOW.
REQ-022 WAIT_LOW: cdc_src_send=0; when cdc_src_rcv=0, go to IDLE; the next grant occurs no earlier than the cycle after IDLE is entered.
REQ-023 Result: a minimum of one idle cycle between consecutive grants; a single requester holding valid receives every slot in turn.
REQ-024 cdc_src_in SHALL remain stable from the grant until the next grant, including through WAIT_LOW and IDLE.
REQ-025 If cdc_src_rcv is high in IDLE, the block SHALL NOT grant until it is low.
REQ-026 Timeout: a counter clears on entry to SEND and increments each SEND cycle; if it reaches TIMEOUT (TIMEOUT != 0), set timeout_err and keep waiting in SEND (never abort a handshake).
REQ-027 The counter SHALL saturate at TIMEOUT and SHALL NOT wrap.
REQ-028 err_clr clears timeout_err; when set and clear occur in the same cycle, set wins.
REQ-029 req_valid changes while not in IDLE SHALL have no effect until IDLE.
REQ-030 req_ready SHALL be all-zero outside grant cycles and one-hot in grant cycles.

Reset
REQ-031 While resetn=0 at a clk edge: state=IDLE, cdc_src_send=0, req_ready=0, cdc_src_in=0, busy=0, timeout_err=0, timeout counter=0, grant_id=NREQ-1 (first search starts at requester 0).
REQ-032 Reset asserted mid-handshake SHALL abandon it immediately; after release, no grant occurs until cdc_src_rcv=0.

Verification
REQ-033 Single request: NREQ=4, req_valid=4'b0100, data 0xDEADBEEF -> req_ready=4'b0100 for 1 cycle; next cycle cdc_src_send=1, cdc_src_in={2'd2, 0xDEADBEEF}; rcv pulse -> send drops; busy falls after rcv falls.
REQ-034 Round-robin: all four valid continuously, CDC model with a 6-cycle rcv round trip -> grant order 0,1,2,3,0,1; every payload is delivered with its matching tag.
REQ-035 Timeout: TIMEOUT=16, rcv held low -> timeout_err rises 16 cycles after send rises; send stays high; a later rcv completes the transfer; err_clr then clears the flag; a same-cycle set and clear leaves it set.
REQ-036 Reset mid-SEND: resetn low for 1 cycle while send=1 -> all outputs at reset values the next cycle; rcv held high -> no grant until rcv=0.
REQ-037 Stability: randomized req_data toggling every cycle during SEND/WAIT_LOW -> cdc_src_in unchanged; req_ready always one-hot or zero.
REQ-038 Integration: connect to the xpm handshake CDC (dst clock 3.3x slower, STAGES=4) with 1000 random requests -> the destination receives every word exactly once, in grant order.
